// File: rtl/mini_cpu_pkg.sv
// Shared types and constants for the mini CPU datapath blocks.
package mini_cpu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift in a bit, trial-subtract, restore on borrow.
module div_sub_stage
    import mini_cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             in_bit_i,
    output logic [WIDTH-1:0] next_rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_i, in_bit_i};
    assign trial   = shifted - {1'b0, divisor_i};

    // trial[WIDTH] is the borrow of the WIDTH+1-bit compare
    assign q_bit_o    = ~trial[WIDTH];
    assign next_rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN to add the is_signed port and two's-complement fix-up.
module seq_divider
    import mini_cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero_flag,
    output logic             overflow_flag
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic             ovfp_q, ovfp_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             sg;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .rem_i      (rem_q),
        .divisor_i  (dvs_q),
        .in_bit_i   (quo_q[WIDTH-1]),
        .next_rem_o (step_rem),
        .q_bit_o    (step_bit)
    );

`ifdef SIGNED_DIV_EN
    assign sg = is_signed;
`else
    assign sg = 1'b0;
`endif

    assign a_neg = sg & dividend[WIDTH-1];
    assign b_neg = sg & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        ovfp_d  = ovfp_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (start) begin
                    state_d = DIV_RUN;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    dvs_d   = b_mag;
                    zero_d  = (divisor == '0);
                    ovfp_d  = sg && (dividend == MIN_NEG) && (divisor == '1);
                    if (divisor == '0) begin
                        // no steps: finalize on the next edge
                        cnt_d  = LAST;
                        quo_d  = '1;
                        rem_d  = dividend;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                    end else begin
                        cnt_d  = '0;
                        quo_d  = a_mag;
                        rem_d  = '0;
                        negq_d = a_neg ^ b_neg;
                        negr_d = a_neg;
                    end
                end
            end
            DIV_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DIV_DONE;
                    quot_d  = negq_q ? (~quo_q + 1'b1) : quo_q;
                    remo_d  = negr_q ? (~rem_q + 1'b1) : rem_q;
                    dbz_d   = zero_q;
                    ovf_d   = ovfp_q;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_bit};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            ovfp_q  <= ovfp_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy             = (state_q == DIV_RUN);
    assign done             = (state_q == DIV_DONE);
    assign quotient         = quot_q;
    assign remainder        = remo_q;
    assign div_by_zero_flag = dbz_q;
    assign overflow_flag    = ovf_q;

endmodule
